// File: rtl/pipelined_mux_tree.sv
// Pipelined N-to-1 word multiplexer built from 2:1 select levels.
// The tree is cut into register stages of LEVELS_PER_STAGE levels each, and
// every stage has a valid/ready handshake.
// Optional macro MUX_SEL_RANGE_CHECK_EN adds the sel_err output, which flags
// transfers whose sel was at or above NUM_INPUTS.
module pipelined_mux_tree #(
  parameter int WIDTH            = 64,
  parameter int NUM_INPUTS       = 32,
  parameter int LEVELS_PER_STAGE = 2,
  localparam int SELW            = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] in,
  input  logic [SELW-1:0]             sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef MUX_SEL_RANGE_CHECK_EN
  , output logic                      sel_err
`endif
);

  localparam int D       = SELW;
  localparam int P       = 1 << D;
  localparam int NSTAGES = (D + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  genvar gi, gl, gw;

  if (NUM_INPUTS < 2 || NUM_INPUTS > 64) begin : g_bad_inputs
    $error("pipelined_mux_tree: NUM_INPUTS must be in 2..64");
  end
  if (LEVELS_PER_STAGE < 1 || LEVELS_PER_STAGE > 6) begin : g_bad_levels
    $error("pipelined_mux_tree: LEVELS_PER_STAGE must be in 1..6");
  end

  // Leaf words, padded with zeros up to a power of two so out-of-range
  // selects fall onto a zero word.
  logic [P*WIDTH-1:0] padded;
  for (gi = 0; gi < P; gi++) begin : g_pad
    if (gi < NUM_INPUTS) begin : g_real
      assign padded[gi*WIDTH +: WIDTH] = in[gi*WIDTH +: WIDTH];
    end else begin : g_zero
      assign padded[gi*WIDTH +: WIDTH] = '0;
    end
  end

`ifdef MUX_SEL_RANGE_CHECK_EN
  logic sel_oor;
  assign sel_oor = ({{(32-SELW){1'b0}}, sel} >= 32'(NUM_INPUTS));
`endif

  for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
    localparam int LO   = gi * LEVELS_PER_STAGE;
    localparam int HI   = (LO + LEVELS_PER_STAGE > D) ? D : LO + LEVELS_PER_STAGE;
    localparam int NL   = HI - LO;
    localparam int NIN  = P >> LO;
    localparam int NOUT = P >> HI;

    logic [NIN*WIDTH-1:0]  din;
    logic [D-LO-1:0]       sin;
    logic                  vin;
    logic                  rdy;
    logic                  vld_reg;
    logic [NOUT*WIDTH-1:0] data_reg;
`ifdef MUX_SEL_RANGE_CHECK_EN
    logic                  ein;
    logic                  err_reg;
`endif

    // Stage inputs come from the block ports for the first stage and from
    // the previous stage register otherwise.
    if (gi == 0) begin : g_src
      assign din = padded;
      assign sin = sel;
      assign vin = in_valid;
`ifdef MUX_SEL_RANGE_CHECK_EN
      assign ein = sel_oor;
`endif
    end else begin : g_src
      assign din = g_stage[gi-1].data_reg;
      assign sin = g_stage[gi-1].g_fwd.sel_reg;
      assign vin = g_stage[gi-1].vld_reg;
`ifdef MUX_SEL_RANGE_CHECK_EN
      assign ein = g_stage[gi-1].err_reg;
`endif
    end

    // An empty stage can always take data, so bubbles collapse upstream.
    if (gi == NSTAGES - 1) begin : g_rdy
      assign rdy = !vld_reg || out_ready;
    end else begin : g_rdy
      assign rdy = !vld_reg || g_stage[gi+1].rdy;
    end

    // Combinational 2:1 levels inside this stage; local level gl uses sin[gl-1].
    for (gl = 0; gl <= NL; gl++) begin : g_lvl
      logic [(NIN>>gl)*WIDTH-1:0] v;
      if (gl == 0) begin : g_leaf
        assign v = din;
      end else begin : g_node
        for (gw = 0; gw < (NIN >> gl); gw++) begin : g_word
          assign v[gw*WIDTH +: WIDTH] = sin[gl-1]
            ? g_lvl[gl-1].v[(2*gw+1)*WIDTH +: WIDTH]
            : g_lvl[gl-1].v[(2*gw)*WIDTH +: WIDTH];
        end
      end
    end

    // Stage register: advance when ready, hold everything when stalled.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_reg  <= 1'b0;
        data_reg <= '0;
      end else if (rdy) begin
        vld_reg <= vin;
        if (vin) data_reg <= g_lvl[NL].v;
      end
    end

    // Remaining upper select bits travel along for the later stages.
    if (HI < D) begin : g_fwd
      logic [D-HI-1:0] sel_reg;
      // Forward the unconsumed select bits with the partial results.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_reg <= '0;
        else if (rdy && vin) sel_reg <= sin[D-LO-1:NL];
      end
    end

`ifdef MUX_SEL_RANGE_CHECK_EN
    // Range flag is qualified by valid so it reads 0 whenever the stage is empty.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) err_reg <= 1'b0;
      else if (rdy) err_reg <= vin && ein;
    end
`endif
  end

  assign in_ready  = g_stage[0].rdy;
  assign out       = g_stage[NSTAGES-1].data_reg;
  assign out_valid = g_stage[NSTAGES-1].vld_reg;
`ifdef MUX_SEL_RANGE_CHECK_EN
  assign sel_err   = g_stage[NSTAGES-1].err_reg;
`endif

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Directed bench for pipelined_mux_tree: default configuration plus a
// 20-input, 8-bit, one-level-per-stage instance. A scoreboard queue holds
// expected words for the default instance.
module tb_pipelined_mux_tree;

  localparam int W  = 64;
  localparam int N  = 32;
  localparam int W2 = 8;
  localparam int N2 = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N*W-1:0]  in;
  logic [4:0]      sel;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]    out;
  logic [N2*W2-1:0] in2;
  logic [4:0]      sel2;
  logic            in_valid2, in_ready2, out_valid2, out_ready2;
  logic [W2-1:0]   out2;
`ifdef MUX_SEL_RANGE_CHECK_EN
  logic            sel_err, sel_err2;
`endif

  pipelined_mux_tree #(.WIDTH(W), .NUM_INPUTS(N), .LEVELS_PER_STAGE(2)) dut (
    .clk(clk), .reset(reset), .in(in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_SEL_RANGE_CHECK_EN
    , .sel_err(sel_err)
`endif
  );

  pipelined_mux_tree #(.WIDTH(W2), .NUM_INPUTS(N2), .LEVELS_PER_STAGE(1)) dut2 (
    .clk(clk), .reset(reset), .in(in2), .sel(sel2), .in_valid(in_valid2),
    .in_ready(in_ready2), .out(out2), .out_valid(out_valid2), .out_ready(out_ready2)
`ifdef MUX_SEL_RANGE_CHECK_EN
    , .sel_err(sel_err2)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] sbq[$];
  logic [63:0] prev_out;
  bit          prev_stall = 1'b0;

  function automatic logic [63:0] w1(input int i);
    return (i < N) ? (64'hA5A5_0000_0000_0000 | 64'(i)) : 64'd0;
  endfunction

  function automatic logic [7:0] w2(input int i);
    return (i < N2) ? 8'(i*13 + 5) : 8'd0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the default instance: push on accept, pop on drain.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      sbq.delete();
    end else begin
      if (prev_stall) check("hold", out, prev_out);
`ifdef MUX_SEL_RANGE_CHECK_EN
      if (!out_valid) check("err_idle", 64'(sel_err), 64'd0);
`endif
      if (out_valid && out_ready) begin
        total++;
        assert (sbq.size() > 0) else begin
          bad++;
          $error("FAIL extra_out observed=empty_queue expected=pending_entry");
        end
        if (sbq.size() > 0) check("data", out, sbq.pop_front());
      end
      if (in_valid && in_ready) sbq.push_back(w1(int'(sel)));
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
    end
  end

  initial begin
    int list[5] = '{16, 24, 28, 30, 31};
    int idx, acc;
    for (int i = 0; i < N; i++) in[i*W +: W] = w1(i);
    for (int i = 0; i < N2; i++) in2[i*W2 +: W2] = w2(i);
    reset = 1'b1; sel = '0; in_valid = 1'b0; out_ready = 1'b1;
    sel2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;

    // Reset state and asynchronous reset pulse
    repeat (2) step();
    check("rst_out", out, 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0; sel = 5'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    check("pre_async_valid", 64'(out_valid), 64'd1);
    check("pre_async_out", out, w1(3));
    #2 reset = 1'b1;
    #1 check("async_valid", 64'(out_valid), 64'd0);
    check("async_out", out, 64'd0);
    step();
    reset = 1'b0; out_ready = 1'b1;
    #1 check("async_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back stream sel = 0..31 with latency check
    for (int i = 0; i < 32; i++) begin
      sel = 5'(i); in_valid = 1'b1;
      #1 check("stream_in_ready", 64'(in_ready), 64'd1);
      step();
      if (i < 4) check("latency_valid", 64'(out_valid), 64'(i >= 2));
    end
    in_valid = 1'b0;
    repeat (5) step();
    check("stream_drain", 64'(sbq.size()), 64'd0);

    // Stall: exactly three accepts, then release
    idx = 0; acc = 0; out_ready = 1'b0;
    for (int j = 0; j < 30 && idx < 5; j++) begin
      if (j == 6) out_ready = 1'b1;
      sel = 5'(list[idx]); in_valid = 1'b1;
      #1;
      if (j == 5) begin
        check("stall_accepts", 64'(acc), 64'd3);
        check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      if (in_ready) begin acc++; idx++; end
      step();
    end
    in_valid = 1'b0;
    check("stall_all_sent", 64'(idx), 64'd5);
    repeat (6) step();
    check("stall_drain", 64'(sbq.size()), 64'd0);

    // Toggling out_ready with random selects
    for (int j = 0; j < 40; j++) begin
      out_ready = (j % 2 == 0);
      sel = 5'($urandom_range(0, 31)); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();
    check("toggle_drain", 64'(sbq.size()), 64'd0);

    // Non-power-of-two instance, one level per stage, latency 5
    sel2 = 5'd19; in_valid2 = 1'b1;
    step();
    sel2 = 5'd25;
    step();
    in_valid2 = 1'b0;
    repeat (2) step();
    check("np2_latency_valid", 64'(out_valid2), 64'd0);
    step();
    check("np2_valid19", 64'(out_valid2), 64'd1);
    check("np2_out19", 64'(out2), 64'(w2(19)));
`ifdef MUX_SEL_RANGE_CHECK_EN
    check("np2_err19", 64'(sel_err2), 64'd0);
`endif
    step();
    check("np2_valid25", 64'(out_valid2), 64'd1);
    check("np2_out25", 64'(out2), 64'd0);
`ifdef MUX_SEL_RANGE_CHECK_EN
    check("np2_err25", 64'(sel_err2), 64'd1);
`endif
    step();
    check("np2_idle", 64'(out_valid2), 64'd0);
`ifdef MUX_SEL_RANGE_CHECK_EN
    check("np2_err_idle", 64'(sel_err2), 64'd0);
`endif

    // Reset with three transfers in flight
    out_ready = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      sel = 5'(j); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    step();
    check("flight_rst_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      check("flight_discard", 64'(out_valid), 64'd0);
    end
    sel = 5'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_early", 64'(out_valid), 64'd0);
    step();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_out", out, w1(7));
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_mux_tree.md
Name: pipelined_mux_tree

Overview:
- Parametrised, pipelined N-to-1 word multiplexer; generalises the single-bit 32:1 select tree to multi-bit words, any input count and configurable pipeline depth.
- Built as a tree of 2:1 select levels with a register bank after every LEVELS_PER_STAGE levels.
- Valid/ready handshake at both ends, so it can sit between the register file read path and downstream datapath consumers that may stall.

Parameters:
WIDTH, 64, bits per input word and per output word.
NUM_INPUTS, 32, number of input words; legal range 2..64, need not be a power of two.
LEVELS_PER_STAGE, 2, 2:1 tree levels between pipeline registers; legal range 1..6.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in  input  NUM_INPUTS*WIDTH  packed input words; word i = in[i*WIDTH +: WIDTH].
sel  input  SELW = max(1, clog2(NUM_INPUTS))  index of the word to forward.
in_valid  input  1  in/sel are valid this cycle.
in_ready  output  1  block accepts in/sel this cycle.
out  output  WIDTH  selected word.
out_valid  output  1  out holds a valid result.
out_ready  input  1  consumer accepts out this cycle.
sel_err  output  1  present only with MUX_SEL_RANGE_CHECK_EN; see Optional Feature.

Behaviour:
- Tree structure:
  - Pad the input set to P = 2^SELW words; padded words are all-zero.
  - Tree depth D = SELW levels. Level j (j = 0 at the leaves) selects on sel[j].
- Pipelining:
  - NSTAGES = ceil(D / LEVELS_PER_STAGE) register stages.
  - A stage register follows levels LEVELS_PER_STAGE-1, 2*LEVELS_PER_STAGE-1, ...; the last stage follows level D-1.
  - Each stage carries the partial results, the unused upper sel bits and a valid bit.
- Latency: an accepted transfer appears on out exactly NSTAGES cycles later when out_ready is held high. Defaults: D = 5, NSTAGES = 3, latency 3.
- Throughput: one transfer per cycle when out_ready stays high.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Stage k is ready when !valid_k || ready_{k+1}; stage NSTAGES+1 is out_ready. in_ready = ready of stage 1.
  - Stalled stages hold their data and valid bits. Bubbles collapse: an empty stage accepts data even while downstream stages are stalled.
  - out, out_valid and sel_err are driven directly from the last stage register, with no combinational path from in to out.
  - in_ready may depend combinationally on out_ready.
- Out-of-range select: sel >= NUM_INPUTS selects a padded word, so out = 0 for that transfer, and the transfer still completes.
- Reset:
  - Asynchronously clears all stage valid bits, data and sel registers.
  - out = 0, out_valid = 0, sel_err = 0. in_ready = 1 from the first cycle after reset deasserts.
  - Reset mid-stream discards all in-flight transfers; nothing is replayed.
- Simultaneous events: accept and drain in the same cycle are allowed at every stage. A full pipeline with out_ready high accepts a new input the same cycle the oldest result leaves.
- Protocol rules: in/sel are sampled only on an accepted transfer. The block does not require in_valid to stay asserted once raised.
- Elaboration: NUM_INPUTS outside 2..64 or LEVELS_PER_STAGE outside 1..6 causes an elaboration error ($error in a generate block).

Optional Feature:
- Macro: MUX_SEL_RANGE_CHECK_EN.
- Defined:
  - sel_err port exists.
  - A flag computed at acceptance (sel >= NUM_INPUTS) travels with the data.
  - sel_err = 1 exactly while the corresponding out_valid = 1. It is 0 when out_valid = 0 and is cleared by reset.
- Undefined:
  - No sel_err port and no flag register.
  - Out-of-range selects still return 0.

Test Plan:
1. Defaults, reset pulse mid-cycle (asynchronous): out = 0, out_valid = 0 immediately; in_ready = 1 after release.
2. Defaults, word i = 64'hA5A5_0000_0000_0000 | i, out_ready = 1, stream sel = 0..31 back-to-back: in_ready stays 1; out_valid rises 3 cycles after the first accept; outputs are 0xA5A5...00 through 0xA5A5...1F in order, one per cycle.
3. Defaults, hold out_ready = 0 while streaming sel = 16, 24, 28, 30, 31: exactly 3 accepts, then in_ready = 0. Release out_ready: words 16, 24, 28, 30, 31 emerge in order with none lost or duplicated.
4. Toggle out_ready every cycle with in_valid = 1 and random sel: every result matches a reference model in order, and out does not change while out_valid && !out_ready.
5. NUM_INPUTS = 20, WIDTH = 8, LEVELS_PER_STAGE = 1 (D = 5, latency 5), sel = 19 then 25:
   - out = word 19, then 8'h00.
   - With MUX_SEL_RANGE_CHECK_EN defined, sel_err = 0 then 1.
6. Reset asserted with 3 transfers in flight: no out_valid for them after release. A new sel = 7 transfer returns word 7 after NSTAGES cycles.
